// File: rtl/alu_pkg.sv
// ALU control code definitions shared between the ALU control block and the
// execute-stage ALU. The codes match the classic MIPS ALU control encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath.
// Ports:
//   alu_ctrl  in   4      ALU control code (see alu_pkg)
//   a, b      in   WIDTH  operands
//   result    out  WIDTH  ALU result (0 for undefined codes)
//   overflow  out  1      signed overflow, ADD/SUB only
//   illegal   out  1      alu_ctrl is not a defined operation
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             illegal
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;
    logic             slt;

    assign sum  = a + b;
    assign diff = a - b;

    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    // Sign of a-b is wrong exactly when the subtraction overflowed.
    assign slt = diff[WIDTH-1] ^ ovf_sub;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (alu_ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD: begin
                result   = sum;
                overflow = ovf_add;
            end
            ALU_SUB: begin
                result   = diff;
                overflow = ovf_sub;
            end
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with a one-deep EX/MEM output register under a
// valid/ready handshake, plus flush, illegal-op flagging and a retire counter.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   upstream handshake (in_ready = !out_valid | out_ready)
//   alu_ctrl, op_a/op_b operation and operands
//   flush               kill held result and any operation offered this cycle
//   out_valid/out_ready downstream handshake
//   result, zero, overflow, illegal   registered ALU outputs
//   illegal_seen        sticky: an illegal op was accepted since reset
//   ops_retired         count of consumed results (wraps)
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             illegal_seen,
    output logic [CNT_W-1:0] ops_retired
);

    logic [WIDTH-1:0] core_result;
    logic             core_overflow;
    logic             core_illegal;
    logic             accept;
    logic             consume;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .alu_ctrl (alu_ctrl),
        .a        (op_a),
        .b        (op_b),
        .result   (core_result),
        .overflow (core_overflow),
        .illegal  (core_illegal)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    // Flush suppresses retirement even if MEM is ready this cycle.
    assign consume  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            result       <= '0;
            zero         <= 1'b0;
            overflow     <= 1'b0;
            illegal      <= 1'b0;
            illegal_seen <= 1'b0;
            ops_retired  <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                result    <= core_result;
                zero      <= (core_result == '0);
                overflow  <= core_overflow;
                illegal   <= core_illegal;
            end else if (out_ready || flush) begin
                out_valid <= 1'b0;
            end

            if (accept && core_illegal) begin
                illegal_seen <= 1'b1;
            end

            if (consume) begin
                ops_retired <= ops_retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_stage.sv
module tb_ex_alu_stage;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;
    logic        illegal_seen;
    logic [31:0] ops_retired;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = '0;

    typedef struct packed {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        o;
    } vec_t;

    ex_alu_stage #(
        .WIDTH (32),
        .CNT_W (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_ctrl     (alu_ctrl),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .overflow     (overflow),
        .illegal      (illegal),
        .illegal_seen (illegal_seen),
        .ops_retired  (ops_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, ALU_AND, '0, '0);
        step(); step();
        checks++;
        if ({out_valid, in_ready, result, zero, overflow, illegal, illegal_seen, ops_retired} !==
            {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset: v=%b rdy=%b res=%h z=%b o=%b ill=%b seen=%b cnt=%0d, want v=0 rdy=1 all zero",
                     out_valid, in_ready, result, zero, overflow, illegal, illegal_seen, ops_retired);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(1'b1, ALU_ADD, 32'h5, 32'h3);
        step();
        drive(1'b0, ALU_ADD, '0, '0);
        checks++;
        if ({out_valid, result, zero, overflow, illegal} !== {1'b1, 32'h8, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add: v=%b res=%h z=%b o=%b ill=%b, want v=1 res=00000008 z=0 o=0 ill=0",
                     out_valid, result, zero, overflow, illegal);
        end
        step();
        exp_cnt++;
        checks++;
        if ({out_valid, ops_retired} !== {1'b0, exp_cnt}) begin
            errors++;
            $display("FAIL add_retire: v=%b cnt=%0d, want v=0 cnt=%0d", out_valid, ops_retired, exp_cnt);
        end
    endtask

    task automatic test_arith();
        vec_t vecs[10];
        vecs[0] = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[1] = '{ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        vecs[3] = '{ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
        vecs[4] = '{ALU_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[5] = '{ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[6] = '{ALU_OR,  32'h000000F0, 32'h00000F00, 32'h00000FF0, 1'b0, 1'b0};
        vecs[7] = '{ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
        vecs[8] = '{ALU_AND, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0};
        vecs[9] = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].c, vecs[i].a, vecs[i].b);
            step();
            checks++;
            if ({out_valid, result, zero, overflow, illegal} !== {1'b1, vecs[i].r, vecs[i].z, vecs[i].o, 1'b0}) begin
                errors++;
                $display("FAIL arith[%0d] ctrl=%b a=%h b=%h: v=%b res=%h z=%b o=%b ill=%b, want v=1 res=%h z=%b o=%b ill=0",
                         i, vecs[i].c, vecs[i].a, vecs[i].b, out_valid, result, zero, overflow, illegal,
                         vecs[i].r, vecs[i].z, vecs[i].o);
            end
        end
        drive(1'b0, ALU_AND, '0, '0);
        step();
        exp_cnt += 10;
        checks++;
        if ({out_valid, ops_retired} !== {1'b0, exp_cnt}) begin
            errors++;
            $display("FAIL arith_retire: v=%b cnt=%0d, want v=0 cnt=%0d", out_valid, ops_retired, exp_cnt);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, ALU_AND, 32'h0000F0F0, 32'h0000FF00);
        step();
        drive(1'b1, ALU_ADD, 32'h1, 32'h1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, in_ready, result, ops_retired} !== {1'b1, 1'b0, 32'h0000F000, exp_cnt}) begin
                errors++;
                $display("FAIL stall[%0d]: v=%b rdy=%b res=%h cnt=%0d, want v=1 rdy=0 res=0000f000 cnt=%0d",
                         i, out_valid, in_ready, result, ops_retired, exp_cnt);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: rdy=%b, want 1", in_ready);
        end
        step();
        exp_cnt++;
        drive(1'b0, ALU_AND, '0, '0);
        checks++;
        if ({out_valid, result, ops_retired} !== {1'b1, 32'h2, exp_cnt}) begin
            errors++;
            $display("FAIL stall_release: v=%b res=%h cnt=%0d, want v=1 res=00000002 cnt=%0d",
                     out_valid, result, ops_retired, exp_cnt);
        end
        step();
        exp_cnt++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, ALU_ADD, 32'd10, 32'd20);
        step();
        out_ready = 1'b1;
        flush     = 1'b1;
        drive(1'b1, ALU_ADD, 32'd100, 32'd1);
        step();
        flush = 1'b0;
        drive(1'b0, ALU_AND, '0, '0);
        checks++;
        if ({out_valid, ops_retired, result} !== {1'b0, exp_cnt, 32'd30}) begin
            errors++;
            $display("FAIL flush: v=%b cnt=%0d res=%0d, want v=0 cnt=%0d res=30",
                     out_valid, ops_retired, result, exp_cnt);
        end
        step();
        checks++;
        if ({out_valid, ops_retired} !== {1'b0, exp_cnt}) begin
            errors++;
            $display("FAIL flush_after: v=%b cnt=%0d, want v=0 cnt=%0d", out_valid, ops_retired, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(1'b1, ALU_ILLEGAL, 32'h3, 32'h4);
        step();
        checks++;
        if ({out_valid, result, zero, overflow, illegal, illegal_seen} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL illegal_1111: v=%b res=%h z=%b o=%b ill=%b seen=%b, want v=1 res=0 z=1 o=0 ill=1 seen=1",
                     out_valid, result, zero, overflow, illegal, illegal_seen);
        end
        drive(1'b1, 4'b0011, 32'h7FFFFFFF, 32'h1);
        step();
        exp_cnt++;
        checks++;
        if ({result, zero, overflow, illegal} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_0011: res=%h z=%b o=%b ill=%b, want res=0 z=1 o=0 ill=1",
                     result, zero, overflow, illegal);
        end
        drive(1'b1, ALU_ADD, 32'h2, 32'h2);
        step();
        exp_cnt++;
        drive(1'b0, ALU_AND, '0, '0);
        checks++;
        if ({out_valid, result, illegal, illegal_seen, ops_retired} !== {1'b1, 32'h4, 1'b0, 1'b1, exp_cnt}) begin
            errors++;
            $display("FAIL illegal_sticky: v=%b res=%h ill=%b seen=%b cnt=%0d, want v=1 res=4 ill=0 seen=1 cnt=%0d",
                     out_valid, result, illegal, illegal_seen, ops_retired, exp_cnt);
        end
        step();
        exp_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        base = exp_cnt;
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, ALU_ADD, 32'(k), 32'(10 * k));
            step();
            checks++;
            if ({out_valid, result} !== {1'b1, 32'(11 * k)}) begin
                errors++;
                $display("FAIL b2b[%0d]: v=%b res=%0d, want v=1 res=%0d", k, out_valid, result, 11 * k);
            end
        end
        checks++;
        if (ops_retired !== base + 32'd3) begin
            errors++;
            $display("FAIL b2b_count: cnt=%0d, want %0d", ops_retired, base + 32'd3);
        end
        drive(1'b1, ALU_SUB, 32'd9, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        checks++;
        if ({out_valid, in_ready, result, illegal_seen, ops_retired} !== {1'b0, 1'b1, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: v=%b rdy=%b res=%h seen=%b cnt=%0d, want v=0 rdy=1 res=0 seen=0 cnt=0",
                     out_valid, in_ready, result, illegal_seen, ops_retired);
        end
        step();
        drive(1'b0, ALU_AND, '0, '0);
        rst_n = 1'b1;
        step();
        checks++;
        if ({out_valid, ops_retired, illegal_seen} !== {1'b0, exp_cnt, 1'b0}) begin
            errors++;
            $display("FAIL post_reset: v=%b cnt=%0d seen=%b, want v=0 cnt=0 seen=0",
                     out_valid, ops_retired, illegal_seen);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_arith();
        test_stall();
        test_flush();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
